muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised, multi-cycle successor to the combinational HI/LO multiplier/divider in the MIPS pipeline execute stage. Holds architectural HI/LO registers and computes signed/unsigned multiply and divide iteratively, one bit per cycle. Uses a start/busy/done handshake so the pipeline interlocks MFHI/MFLO on busy. Supports pipeline flush and direct HI/LO writes (MTHI/MTLO).

Parameters:
W, 32, operand width and HI/LO width; even, >= 4.
CW, $clog2(W+1), iteration counter width (derived, localparam).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
start  in  1  launch operation; sampled only when busy=0
op  in  2  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div
a  in  W  operand A / dividend, sampled with start
b  in  W  operand B / divisor, sampled with start
flush  in  1  abort in-flight operation
hi_we  in  1  write wdata to HI (MTHI)
lo_we  in  1  write wdata to LO (MTLO)
wdata  in  W  HI/LO write data
busy  out  1  operation in flight
done  out  1  one-cycle pulse, HI/LO updated this edge
dz  out  1  divide-by-zero flag, valid with done
hi  out  W  HI register
lo  out  W  LO register

Behaviour:
- Reset (rst_n=0, async): state IDLE; hi=lo=0; busy=done=dz=0; counter=0.
- States: IDLE, CALC, FIX.
- IDLE: start=1 at edge E0 -> latch |a|,|b| (signed ops) or a,b raw, plus result-sign bits; counter=W; busy=1; go CALC.
- CALC: one shift-add (mul) or one restoring subtract-shift (div) per edge; counter decrements; at counter=1 the edge moves to FIX. W edges total.
- FIX: a single edge applies the sign correction and writes HI/LO; done=1 and busy=0 from that edge for one cycle; -> IDLE. Result visible W+1 edges after E0.
- Mul: {hi,lo} = full 2W-bit product; signed product negated if sign(a)!=sign(b).
- Div: lo=quotient, hi=remainder. Quotient negated if signs differ; remainder takes dividend's sign (truncating division).
- Signed overflow, -2^(W-1) / -1: lo=0x80..0, hi=0, dz=0.
- b=0 on div: hi/lo unchanged, done pulses with dz=1. dz is cleared on the next start.
- done is 0 in every cycle except the FIX exit. start while busy=1 is ignored.
- flush=1 in any state -> IDLE next edge; busy=0; no done; hi/lo unchanged. flush with start in the same cycle: flush wins, nothing launched.
- hi_we/lo_we: applied only when state is IDLE and start=0. Ignored while busy or when start=1 in the same cycle (start wins).
- Reset mid-operation: immediate return to reset values.

Optional Feature:
Macro MULDIV_ACC_EN.
- Defined: adds input ports acc (1) and sub (1), sampled with start on mul ops. acc=1 makes the FIX edge write {hi,lo} = {hi,lo} +/- product (sub selects minus), modulo 2^(2W), using the HI/LO values at FIX. This gives MADD/MADDU/MSUB/MSUBU. acc is ignored on div.
- Undefined: ports absent; mul always overwrites HI/LO.

Decomposition:
- Package muldiv_pkg: op encoding constants (OP_MULS, OP_MULU, OP_DIVS, OP_DIVU) and the state enum (IDLE, CALC, FIX).
- Sub-module muldiv_negate: W-bit conditional two's-complement negate. Instantiated for operand abs and result fix-up.

Test Plan:
- W=32, signed mul a=7, b=0xFFFFFFFD -> after 33 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- Unsigned mul a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned div 100/7 -> lo=14, hi=2.
- Div b=0 with hi=0x11, lo=0x22 preloaded via hi_we/lo_we -> done=1, dz=1, hi/lo still 0x11/0x22. Signed 0x80000000 / -1 -> lo=0x80000000, hi=0, dz=0.
- Start mul, flush at cycle 10 -> busy=0 next edge, no done, hi/lo unchanged. hi_we during busy -> hi unchanged.
- rst_n low at cycle 5 of a div -> all outputs 0 asynchronously. With MULDIV_ACC_EN, hi:lo=0:5 then acc mul 3*4 -> lo=17; sub=1 -> lo=0xFFFFFFF9, hi=0xFFFFFFFF.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings and FSM states for the
// iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULS = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIVS = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement negate.
// cin_i lets two instances chain into a 2W-bit negate.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic         cin_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    // Invert and add carry-in when negating, else pass through
    always_comb begin
        y_o = x_i;
        if (neg_i) y_o = ~x_i + W'(cin_i);
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle HI/LO multiplier/divider, one bit per cycle.
// Optional MULDIV_ACC_EN adds acc/sub ports for MADD/MSUB style ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [W-1:0] wdata,
`ifdef MULDIV_ACC_EN
    input  logic         acc,
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic         dz,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(W + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic           div_q, sgn_q, rsgn_q, zero_q;
    logic           dz_q, done_q;
    logic [W-1:0]   mc_q, ph_q, pl_q;
    logic [W-1:0]   hi_q, lo_q;
`ifdef MULDIV_ACC_EN
    logic           acc_q, sub_q;
    logic [2*W-1:0] accsum;
`endif

    logic           neg_a, neg_b;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     msum, drem, ddiff;
    logic           dge;
    logic [W-1:0]   ph_d, pl_d;
    logic [W-1:0]   fix_hi, fix_lo;
    logic           hi_neg, hi_cin;

    assign neg_a = ~op[0] & a[W-1];
    assign neg_b = ~op[0] & b[W-1];

    muldiv_negate #(.W(W)) u_abs_a (
        .neg_i (neg_a),
        .cin_i (1'b1),
        .x_i   (a),
        .y_o   (abs_a)
    );

    muldiv_negate #(.W(W)) u_abs_b (
        .neg_i (neg_b),
        .cin_i (1'b1),
        .x_i   (b),
        .y_o   (abs_b)
    );

    // One shift-add or restoring subtract-shift step
    always_comb begin
        msum  = {1'b0, ph_q} + (pl_q[0] ? {1'b0, mc_q} : '0);
        drem  = {ph_q, pl_q[W-1]};
        ddiff = drem - {1'b0, mc_q};
        dge   = ~ddiff[W];
        ph_d  = msum[W:1];
        pl_d  = {msum[0], pl_q[W-1:1]};
        if (div_q) begin
            ph_d = dge ? ddiff[W-1:0] : drem[W-1:0];
            pl_d = {pl_q[W-2:0], dge};
        end
    end

    // Product is a 2W negate; remainder follows dividend sign
    assign hi_neg = div_q ? rsgn_q : sgn_q;
    assign hi_cin = div_q | (pl_q == '0);

    muldiv_negate #(.W(W)) u_fix_lo (
        .neg_i (sgn_q),
        .cin_i (1'b1),
        .x_i   (pl_q),
        .y_o   (fix_lo)
    );

    muldiv_negate #(.W(W)) u_fix_hi (
        .neg_i (hi_neg),
        .cin_i (hi_cin),
        .x_i   (ph_q),
        .y_o   (fix_hi)
    );

`ifdef MULDIV_ACC_EN
    // Accumulate product into current HI/LO, modulo 2^(2W)
    always_comb begin
        accsum = {hi_q, lo_q} + {fix_hi, fix_lo};
        if (sub_q) accsum = {hi_q, lo_q} - {fix_hi, fix_lo};
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; flush always wins
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = CALC;
                CALC:    if (cnt_q == CW'(1)) state_d = FIX;
                FIX:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        dz   = dz_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // Datapath: operand latch, iteration, result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= 1'b0;
            sgn_q  <= 1'b0;
            rsgn_q <= 1'b0;
            zero_q <= 1'b0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
            mc_q   <= '0;
            ph_q   <= '0;
            pl_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef MULDIV_ACC_EN
            acc_q  <= 1'b0;
            sub_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                cnt_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            cnt_q  <= CW'(W);
                            div_q  <= op[1];
                            sgn_q  <= neg_a ^ neg_b;
                            rsgn_q <= neg_a;
                            zero_q <= (b == '0);
                            dz_q   <= 1'b0;
                            mc_q   <= abs_b;
                            ph_q   <= '0;
                            pl_q   <= abs_a;
`ifdef MULDIV_ACC_EN
                            acc_q  <= acc & ~op[1];
                            sub_q  <= sub;
`endif
                        end else begin
                            if (hi_we) hi_q <= wdata;
                            if (lo_we) lo_q <= wdata;
                        end
                    end
                    CALC: begin
                        ph_q  <= ph_d;
                        pl_q  <= pl_d;
                        cnt_q <= cnt_q - CW'(1);
                    end
                    FIX: begin
                        done_q <= 1'b1;
                        if (div_q && zero_q) begin
                            dz_q <= 1'b1;
`ifdef MULDIV_ACC_EN
                        end else if (acc_q) begin
                            {hi_q, lo_q} <= accsum;
`endif
                        end else begin
                            hi_q <= fix_hi;
                            lo_q <= fix_lo;
                        end
                    end
                    default: cnt_q <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a done-driven scoreboard.
// Build with +define+MULDIV_ACC_EN to also exercise accumulate ops.
module tb_muldiv_unit;

    localparam int W = 32;

    typedef struct packed {
        logic         dz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic         clk, rst_n, start, flush, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         acc, sub;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n;

    muldiv_unit #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
`ifdef MULDIV_ACC_EN
        .acc   (acc),
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [65:0] act,
                       input logic [65:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: hi=%h lo=%h", hi, lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({dz, hi, lo} !== e) begin
                    bad++;
                    $display("FAIL result: got dz=%b hi=%h lo=%h want dz=%b hi=%h lo=%h",
                             dz, hi, lo, e.dz, e.hi, e.lo);
                end
            end
        end
    end

    // mode 0 plain, 1 HI/LO write mid-busy, 2 write alongside start
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edz,
                          input int mode, output int cnt);
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        if (mode == 2) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        end
        sb.push_back('{dz: edz, hi: ehi, lo: elo});
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            if (mode == 1 && cnt == 5) begin
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            hi_we = 1'b0; lo_we = 1'b0;
        end
        if (cnt >= 100) begin
            total++; bad++;
            $display("FAIL timeout: busy never dropped");
        end
        @(negedge clk);
    endtask

    task automatic write_hl(input logic [W-1:0] h, input logic [W-1:0] l);
        @(negedge clk);
        hi_we = 1'b1; wdata = h;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = l;
        @(negedge clk);
        lo_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; op = 2'b00;
        a = '0; b = '0; wdata = '0; acc = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {busy, done, dz, hi, lo}, '0);
        rst_n = 1'b1;

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, n);
        chk("busy_cycles", 66'(n), 66'd33);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, n);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 0, n);
        run_op(2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, n);
        run_op(2'b10, 32'd7, -32'sd2, 32'h1, 32'hFFFF_FFFD, 1'b0, 0, n);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, n);

        write_hl(32'h11, 32'h22);
        chk("mthi_mtlo", {2'b0, hi, lo}, {2'b0, 32'h11, 32'h22});
        run_op(2'b11, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 0, n);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0, n);

        // flush mid-multiply: no done, HI/LO kept
        @(negedge clk);
        op = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {65'b0, busy}, 66'd0);
        repeat (40) @(negedge clk);
        chk("flush_hilo", {2'b0, hi, lo}, {2'b0, 32'h0, 32'h8000_0000});

        // flush and start together: nothing launched
        op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start", {65'b0, busy}, 66'd0);
        repeat (40) @(negedge clk);

        write_hl(32'h11, 32'h22);
        run_op(2'b11, 32'd9, 32'd0, 32'h11, 32'h22, 1'b1, 1, n);
        run_op(2'b11, 32'd9, 32'd0, 32'h11, 32'h22, 1'b1, 2, n);

        // asynchronous reset mid-divide
        @(negedge clk);
        op = 2'b10; a = 32'd50; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {busy, done, dz, hi, lo}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {65'b0, busy}, 66'd0);

`ifdef MULDIV_ACC_EN
        write_hl(32'h0, 32'h5);
        acc = 1'b1; sub = 1'b0;
        run_op(2'b01, 32'd3, 32'd4, 32'h0, 32'd17, 1'b0, 0, n);
        write_hl(32'h0, 32'h5);
        sub = 1'b1;
        run_op(2'b00, 32'd3, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 0, n);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, n);
        acc = 1'b0; sub = 1'b0;
`endif

        chk("sb_drained", 66'(sb.size()), 66'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
